// File: rtl/ifetch_ctrl.sv
// IF-stage fetch controller: issues I-cache word reads, stalls the PC on misses/ID stalls, loads IF/ID.
// Optional macro IFETCH_REPEAT_BUF_EN adds a one-entry buffer that re-serves the last delivered word.
module ifetch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  input  logic        id_stall_i,
  output logic        stall_o,
  output logic        mem_read_o,
  output logic [29:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_stall_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 30;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, FETCH, MISS} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic            kill_q;
  logic            deliver;
  logic            addr_ld;
  logic            buf_hit;
  logic [AW-1:0]   dlv_addr;
  logic [XLEN-1:0] dlv_data;
  logic            unused_pc;

  assign unused_pc = ^pc_i[1:0];

`ifdef IFETCH_REPEAT_BUF_EN
  logic            buf_valid;
  logic [AW-1:0]   buf_addr;
  logic [XLEN-1:0] buf_data;

  assign buf_hit = buf_valid && (pc_i[31:2] == buf_addr);

  // Last delivered word, reused while the PC is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (deliver) begin
      buf_valid <= 1'b1;
      buf_addr  <= dlv_addr;
      buf_data  <= dlv_data;
    end
  end
`else
  assign buf_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, cache request and delivery decode
  always_comb begin
    state_d    = state_q;
    mem_read_o = 1'b0;
    mem_addr_o = addr_q;
    deliver    = 1'b0;
    addr_ld    = 1'b0;
    dlv_addr   = addr_q;
    dlv_data   = mem_rdata_i;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_addr_o = pc_i[31:2];
        dlv_addr   = pc_i[31:2];
        if (buf_hit) begin
          deliver = 1'b1;
`ifdef IFETCH_REPEAT_BUF_EN
          dlv_data = buf_data;
`endif
        end else begin
          mem_read_o = 1'b1;
          if (mem_stall_i) begin
            addr_ld = 1'b1;
            state_d = MISS;
          end else begin
            deliver = 1'b1;
          end
        end
      end
      MISS: begin
        mem_read_o = 1'b1;
        if (!mem_stall_i) begin
          deliver = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    stall_o = (state_q == IDLE) | (mem_read_o & mem_stall_i) | id_stall_i;
  end

  // Miss address stays stable for the cache while the miss is outstanding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       addr_q <= '0;
    else if (addr_ld) addr_q <= pc_i[31:2];
  end

  // A flush seen while stalled must turn the eventual word into a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       kill_q <= 1'b0;
    else if (deliver && !id_stall_i)  kill_q <= 1'b0;
    else if (flush_i && stall_o)      kill_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_o       <= NOP;
      pc_o          <= '0;
      instr_valid_o <= 1'b0;
    end else if (!id_stall_i) begin
      if (deliver) begin
        instr_o       <= dlv_data;
        pc_o          <= {dlv_addr, 2'b00};
        instr_valid_o <= ~(flush_i | kill_q);
      end else if (flush_i) begin
        instr_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/ifetch_ctrl.md
# ifetch_ctrl

Instruction-fetch controller for the IF stage of the pipelined core. It consumes the PC register's current address, issues word reads to the instruction cache (L1I backed by L2), and writes the returned word into the IF/ID pipeline register. It generates the stall that freezes the PC register while a cache miss or a downstream stall is in progress. It also applies branch flushes, turning the fetched word into a bubble.

## Interface
- No parameters.
- clk  in  1  core clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- pc_i  in  32  current fetch address from PC register; bits [1:0] are ignored.
- flush_i  in  1  kill current/pending fetch (taken branch or jump resolved downstream).
- id_stall_i  in  1  ID stage cannot accept a new instruction this cycle.
- stall_o  out  1  to PC register stall input; PC must hold while high.
- mem_read_o  out  1  read request to instruction cache.
- mem_addr_o  out  30  word address (pc[31:2]) to instruction cache.
- mem_rdata_i  in  32  read data; valid in any cycle with mem_read_o=1 and mem_stall_i=0.
- mem_stall_i  in  1  cache busy/miss; request and address must stay stable while high.
- instr_o  out  32  IF/ID instruction register.
- pc_o  out  32  IF/ID PC register (address of instr_o, bits [1:0]=0).
- instr_valid_o  out  1  instr_o holds a real instruction (0 = bubble).

## Operation
- State machine with states IDLE, FETCH and MISS.
- **IDLE**
  - Entered only from reset.
  - mem_read_o=0 and stall_o=1.
  - Moves unconditionally to FETCH on the next clock.
- **FETCH**
  - mem_read_o=1 and mem_addr_o=pc_i[31:2], driven combinationally.
  - If mem_stall_i=1: latch pc_i into addr_q and go to MISS.
  - Else the word is delivered this cycle; stay in FETCH.
- **MISS**
  - mem_read_o=1 and mem_addr_o=addr_q, held stable regardless of pc_i.
  - When mem_stall_i=0 the word is delivered; return to FETCH.
- **Delivery**: a cycle with mem_read_o=1 and mem_stall_i=0.
  - If id_stall_i=0: load instr_o<=mem_rdata_i, pc_o<={addr,2'b00}, instr_valid_o<=~(flush_i|kill_q).
  - If id_stall_i=1: the IF/ID registers hold and the word is dropped. The PC is held, so the same address is fetched again next cycle.
- **kill_q**
  - Set by flush_i in any cycle where stall_o=1.
  - Cleared on delivery with id_stall_i=0.
  - Guarantees that a word fetched under a flush becomes a bubble.
- **Flush in a non-delivery cycle**: when flush_i=1 and id_stall_i=0 and there is no delivery, instr_valid_o<=0 immediately.
- **stall_o** = (state==IDLE) | (mem_read_o & mem_stall_i) | id_stall_i. It is combinational.
- **Branch redirect**: the hazard unit keeps the branch target pending while stall_o=1. This block does not store redirect targets.
- **Reset values** (asynchronous): state=IDLE, instr_o=32'h0000_0013 (NOP), pc_o=0, instr_valid_o=0, kill_q=0, addr_q=0.
- **Reset mid-miss**: the request is abandoned (mem_read_o=0 in IDLE). The cache is reset by the same rst_n.

## Timing
- **Hit latency**: the address is presented in cycle N; instr_o/pc_o/instr_valid_o are valid after the rising edge ending cycle N. This is one register stage.
- **Miss**: stall_o is high for every cycle that mem_stall_i is high. The IF/ID update happens on the edge of the first cycle with mem_stall_i=0.
- **Back-to-back hits**: throughput is one instruction per cycle with stall_o=0.
- **Paths**: mem_stall_i→stall_o and id_stall_i→stall_o are combinational. pc_i→mem_addr_o is combinational in FETCH only.
- **Simultaneous events**:
  - flush_i and delivery in the same cycle → bubble.
  - flush_i and id_stall_i → registers hold, and kill_q is set.

## Configuration
- **IFETCH_REPEAT_BUF_EN defined**
  - Adds a one-entry buffer of buf_valid, buf_addr[29:0] and buf_data[31:0].
  - The buffer is written on every delivery and cleared on reset.
  - In FETCH, if buf_valid and pc_i[31:2]==buf_addr:
    - mem_read_o=0 and the buffer counts as a delivery with mem_stall_i treated as 0.
    - Data comes from buf_data.
  - This removes repeated cache accesses while the PC is held by id_stall_i.
- **IFETCH_REPEAT_BUF_EN undefined**: no buffer; every FETCH cycle issues mem_read_o=1.

## Test plan
- Reset, then pc_i=0x0, no cache stall → stall_o=1 for one cycle (IDLE). The next edge gives instr_o=mem_rdata_i, pc_o=0x0, instr_valid_o=1.
- pc_i=0x40 with mem_stall_i high for 5 cycles → stall_o=1 for 5 cycles and mem_addr_o=0x10 constant even if pc_i is perturbed. The IF/ID update follows on the 6th cycle.
- flush_i pulsed in cycle 2 of a 4-cycle miss → delivered word gives instr_valid_o=0, kill_q cleared. The following fetch gives instr_valid_o=1.
- id_stall_i=1 for 3 cycles during hits at pc 0x100 → IF/ID holds its previous value and stall_o=1. With the macro defined, mem_read_o=0 on cycles 2–3. Without it, mem_read_o=1 each cycle.
- Sequential hits at pc 0x0,0x4,0x8,0xC → four valid instructions on four consecutive edges with stall_o=0.
- rst_n asserted mid-miss → all outputs at reset values asynchronously, mem_read_o=0, and a clean restart from IDLE.
